// File: rtl/unary_stream_encoder.sv
// Binary operand pair -> unary A/B bitstreams, then adder write-out sequencing (STREAM, WRITE, done).
// Define UNARY_ENC_STOCHASTIC_EN for LFSR-based stochastic streams instead of thermometer code.
module unary_stream_encoder #(
   parameter int WIDTH     = 4,
   parameter int FRAME_LEN = 15,
   parameter int WRITE_LEN = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] val_a,
   input  logic [WIDTH-1:0] val_b,
   input  logic             abort,
   output logic             ready,
   output logic             A,
   output logic             B,
   output logic             en,
   output logic             read_or_write,
   output logic             done,
   output logic             sat
);
   localparam int IW = $clog2(FRAME_LEN + 1);
   localparam int CW = $clog2(WRITE_LEN + 1);
   localparam logic [WIDTH-1:0] FL_W     = WIDTH'(FRAME_LEN);
   localparam logic [IW-1:0]    FL_I     = IW'(FRAME_LEN);
   localparam logic [IW-1:0]    LAST_IDX = IW'(FRAME_LEN - 1);
   localparam logic [CW-1:0]    LAST_WR  = CW'(WRITE_LEN - 1);

   typedef enum logic [1:0] {IDLE, STREAM, WRITE} state_t;

   state_t        state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic [CW-1:0] wcnt, wcnt_n;
   logic [IW-1:0] a_q, a_n, b_q, b_n;
   logic          sat_n, ready_n, en_n, row_n, done_n, a_bit_n, b_bit_n;

`ifdef UNARY_ENC_STOCHASTIC_EN
   localparam logic [31:0] TAPS = (WIDTH == 2) ? 32'h3  : (WIDTH == 3) ? 32'h6  :
                                  (WIDTH == 4) ? 32'hC  : (WIDTH == 5) ? 32'h14 :
                                  (WIDTH == 6) ? 32'h30 : (WIDTH == 7) ? 32'h60 :
                                  (WIDTH == 8) ? 32'hB8 : 32'h0;
   localparam logic [WIDTH-1:0] TAP_MASK = TAPS[WIDTH-1:0];

   // Every nonzero LFSR state appears once per frame, so the 1-count equals the operand.
   if (FRAME_LEN != (1 << WIDTH) - 1 || TAPS == 32'h0) begin : g_cfg_err
      $error("stochastic mode needs FRAME_LEN == 2**WIDTH-1 and WIDTH in 2..8");
   end

   logic [WIDTH-1:0] lfsr, lfsr_n;
`endif

   always_comb begin
      state_n = state;
      idx_n   = idx;
      wcnt_n  = wcnt;
      a_n     = a_q;
      b_n     = b_q;
      sat_n   = sat;
      ready_n = 1'b0;
      en_n    = 1'b0;
      row_n   = 1'b0;
      done_n  = 1'b0;
`ifdef UNARY_ENC_STOCHASTIC_EN
      lfsr_n  = lfsr;
`endif
      unique case (state)
         IDLE: begin
            ready_n = 1'b1;
            if (load && !abort) begin
               state_n = STREAM;
               idx_n   = '0;
               a_n     = (val_a > FL_W) ? FL_I : IW'(val_a);
               b_n     = (val_b > FL_W) ? FL_I : IW'(val_b);
               sat_n   = (val_a > FL_W) || (val_b > FL_W);
               ready_n = 1'b0;
               en_n    = 1'b1;
`ifdef UNARY_ENC_STOCHASTIC_EN
               lfsr_n  = WIDTH'(1);
`endif
            end
         end
         STREAM: begin
            en_n = 1'b1;
            if (abort) begin
               state_n = IDLE;
               sat_n   = 1'b0;
               en_n    = 1'b0;
               ready_n = 1'b1;
            end else if (idx == LAST_IDX) begin
               state_n = WRITE;
               wcnt_n  = '0;
               row_n   = 1'b1;
            end else begin
               idx_n = idx + 1'b1;
`ifdef UNARY_ENC_STOCHASTIC_EN
               lfsr_n = {lfsr[WIDTH-2:0], ^(lfsr & TAP_MASK)};
`endif
            end
         end
         WRITE: begin
            en_n  = 1'b1;
            row_n = 1'b1;
            if (abort) begin
               state_n = IDLE;
               sat_n   = 1'b0;
               en_n    = 1'b0;
               row_n   = 1'b0;
               ready_n = 1'b1;
            end else if (wcnt == LAST_WR) begin
               state_n = IDLE;
               en_n    = 1'b0;
               row_n   = 1'b0;
               ready_n = 1'b1;
               done_n  = 1'b1;
            end else begin
               wcnt_n = wcnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      // Stream bits are registered from next-state values so they line up with en.
`ifdef UNARY_ENC_STOCHASTIC_EN
      a_bit_n = (state_n == STREAM) && (IW'(lfsr_n) <= a_n);
      b_bit_n = (state_n == STREAM) && (IW'(lfsr_n) <= b_n);
`else
      a_bit_n = (state_n == STREAM) && (idx_n < a_n);
      b_bit_n = (state_n == STREAM) && (idx_n < b_n);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         idx           <= '0;
         wcnt          <= '0;
         a_q           <= '0;
         b_q           <= '0;
         sat           <= 1'b0;
         ready         <= 1'b1;
         A             <= 1'b0;
         B             <= 1'b0;
         en            <= 1'b0;
         read_or_write <= 1'b0;
         done          <= 1'b0;
`ifdef UNARY_ENC_STOCHASTIC_EN
         lfsr          <= WIDTH'(1);
`endif
      end else begin
         state         <= state_n;
         idx           <= idx_n;
         wcnt          <= wcnt_n;
         a_q           <= a_n;
         b_q           <= b_n;
         sat           <= sat_n;
         ready         <= ready_n;
         A             <= a_bit_n;
         B             <= b_bit_n;
         en            <= en_n;
         read_or_write <= row_n;
         done          <= done_n;
`ifdef UNARY_ENC_STOCHASTIC_EN
         lfsr          <= lfsr_n;
`endif
      end
   end
endmodule

// File: tb/tb_unary_stream_encoder.sv
// Directed bench for unary_stream_encoder: stream shapes, write-out timing, saturation, abort and reset.
module tb_unary_stream_encoder;
`ifdef UNARY_ENC_STOCHASTIC_EN
   localparam int W = 4;
`else
   localparam int W = 5;
`endif
   localparam int FL = 15;
   localparam int WL = 20;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] val_a = '0;
   logic [W-1:0] val_b = '0;
   logic         ready, A, B, en, read_or_write, done, sat;

   int nvec = 0;
   int nerr = 0;

   unary_stream_encoder #(.WIDTH(W), .FRAME_LEN(FL), .WRITE_LEN(WL)) dut (
      .clk(clk), .rst(rst), .load(load), .val_a(val_a), .val_b(val_b), .abort(abort),
      .ready(ready), .A(A), .B(B), .en(en), .read_or_write(read_or_write),
      .done(done), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {ready, en, read_or_write, A, B, done, sat}
   function automatic logic [31:0] outs();
      return 32'({ready, en, read_or_write, A, B, done, sat});
   endfunction

   task automatic run_op(input string tag, input int va, input int vb,
                         input logic [31:0] exp_apat, input logic [31:0] exp_bpat,
                         input logic exp_sat, output logic [31:0] apat);
      logic [31:0] bpat;
      int en_n, row_n, done_n, done_at, row_first, rdy_lo, stray;
      logic sat_all, sat_any, en1;
      apat = '0; bpat = '0;
      en_n = 0; row_n = 0; done_n = 0; done_at = 0; row_first = 0; rdy_lo = 0; stray = 0;
      sat_all = 1'b1; sat_any = 1'b0; en1 = 1'b0;
      @(negedge clk);
      chk({tag, "/en_pre"}, 32'(en), 32'd0);
      load = 1'b1; val_a = W'(va); val_b = W'(vb);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         load = 1'b0;
         if (c == 1) en1 = en;
         if (c <= FL) begin
            apat[c-1] = A;
            bpat[c-1] = B;
         end else if (A || B) stray++;
         if (en) en_n++;
         if (read_or_write) row_n++;
         if (read_or_write && row_first == 0) row_first = c;
         if (done) begin done_n++; done_at = c; end
         if (!ready) rdy_lo++;
         if (c <= 36) begin sat_all &= sat; sat_any |= sat; end
      end
      chk({tag, "/pat_a"}, apat, exp_apat);
      chk({tag, "/pat_b"}, bpat, exp_bpat);
      chk({tag, "/en_c1"}, 32'(en1), 32'd1);
      chk({tag, "/stray"}, 32'(stray), 32'd0);
      chk({tag, "/en_cnt"}, 32'(en_n), 32'd35);
      chk({tag, "/row_first"}, 32'(row_first), 32'd16);
      chk({tag, "/row_cnt"}, 32'(row_n), 32'd20);
      chk({tag, "/done_cnt"}, 32'(done_n), 32'd1);
      chk({tag, "/done_at"}, 32'(done_at), 32'd36);
      chk({tag, "/rdy_lo"}, 32'(rdy_lo), 32'd35);
      chk({tag, "/sat_op"}, 32'(exp_sat ? sat_all : sat_any), 32'(exp_sat));
      chk({tag, "/sat_hold"}, 32'(sat), 32'(exp_sat));
   endtask

   initial begin
      logic [31:0] apat, apat2;
      int row_first, done_n;
      repeat (2) @(negedge clk);
      chk("reset_outs", outs(), 32'b1000000);
      rst = 1'b0;

`ifdef UNARY_ENC_STOCHASTIC_EN
      // lfsr order 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8 -> values <= 9 at frame slots 0-5,8,10,14
      run_op("stoch1", 9, 15, 32'h453F, 32'h7FFF, 1'b0, apat);
      run_op("stoch2", 9, 15, 32'h453F, 32'h7FFF, 1'b0, apat2);
      chk("stoch_repeat", apat2, apat);
`else
      run_op("op_7_3", 7, 3, 32'h007F, 32'h0007, 1'b0, apat);
      run_op("op_0_15", 0, 15, 32'h0000, 32'h7FFF, 1'b0, apat);
      run_op("op_sat", 20, 2, 32'h7FFF, 32'h0003, 1'b1, apat);
      run_op("op_1_1", 1, 1, 32'h0001, 32'h0001, 1'b0, apat);

      // load during STREAM is ignored; reset at WRITE cycle 5 leaves no done pulse
      @(negedge clk);
      load = 1'b1; val_a = W'(7); val_b = W'(3);
      apat = '0; row_first = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         load = (c == 3);
         if (c == 3) begin val_a = W'(1); val_b = W'(1); end
         if (c <= FL) apat[c-1] = A;
         if (read_or_write && row_first == 0) row_first = c;
         if (c == 20) rst = 1'b1;
      end
      chk("ign_load/pat_a", apat, 32'h007F);
      chk("ign_load/row_first", 32'(row_first), 32'd16);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_outs", outs(), 32'b1000000);
      done_n = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || en) done_n++;
      end
      chk("mid_rst_quiet", 32'(done_n), 32'd0);

      // abort at STREAM cycle 4 of a saturating op clears sat and returns to IDLE
      @(negedge clk);
      load = 1'b1; val_a = W'(20); val_b = W'(9);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         load = 1'b0;
      end
      chk("pre_abort_sat", 32'(sat), 32'd1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_outs", outs(), 32'b1000000);
      run_op("after_abort", 2, 2, 32'h0003, 32'h0003, 1'b0, apat);

      // load and abort together in IDLE: abort wins
      @(negedge clk);
      load = 1'b1; abort = 1'b1; val_a = W'(5); val_b = W'(5);
      @(negedge clk);
      load = 1'b0; abort = 1'b0;
      chk("ld_abort_outs", outs(), 32'b1000000);
      @(negedge clk);
      chk("ld_abort_idle", 32'({ready, en}), 32'b10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
